// File: rtl/sdram_burst_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_burst_arbiter_pkg                                              |
// | Command opcodes, FSM state encoding and SETTLE length for the        |
// | SDRAM burst arbiter.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sdram_burst_arbiter_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  localparam int SETTLE_CYCLES = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_burst_addr_gen                                                 |
// | Frame address counter: steps by one burst, wraps to 0 at the frame   |
// | end with a registered frame_done pulse.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_burst_addr_gen
  import sdram_burst_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_WORDS = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] FRAME = (ADDR_W+1)'(FRAME_WORDS);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W:0]   next_sum;

  // One extra bit so a frame ending exactly at 2^ADDR_W still compares correctly.
  assign next_sum = {1'b0, addr_q} + STEP;

  always_comb begin
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    if (advance) begin
      if (next_sum == FRAME) begin
        addr_d       = '0;
        frame_done_d = 1'b1;
      end else begin
        addr_d = next_sum[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign addr       = addr_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_burst_arbiter                                                  |
// | Picks write burst / read burst / refresh for the SDRAM command       |
// | engine. Optional watchdog: define SDRAM_ARB_WDOG_EN.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_burst_arbiter
  import sdram_burst_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_SIZE = 9,
  parameter int unsigned BURST_LEN      = 64,
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned FRAME_WORDS    = 307200,
  parameter int unsigned WDOG_CYCLES    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enable,
  input  logic                    rd_enable,
  input  logic [FIFO_ADDR_SIZE:0] wr_level,
  input  logic [FIFO_ADDR_SIZE:0] rd_space,
  input  logic                    ref_req,
  output logic                    ref_ack,
  output logic                    cmd_valid,
  output logic [1:0]              cmd_op,
  output logic [ADDR_W-1:0]       cmd_addr,
  input  logic                    cmd_ready,
  input  logic                    cmd_done,
  output logic                    wr_frame_done,
  output logic                    rd_frame_done
`ifdef SDRAM_ARB_WDOG_EN
  ,
  output logic                    wdog_err
`endif
);

  localparam logic [FIFO_ADDR_SIZE:0] BURST_LVL   = (FIFO_ADDR_SIZE+1)'(BURST_LEN);
  localparam logic [1:0]              SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  if (((BURST_LEN & (BURST_LEN - 1)) != 0) || (BURST_LEN > (1 << FIFO_ADDR_SIZE)) ||
      ((FRAME_WORDS % BURST_LEN) != 0) || (WDOG_CYCLES < 1)) begin : g_bad_params
    $error("sdram_burst_arbiter: inconsistent parameters");
  end

  arb_state_e        state_q, state_d;
  logic [1:0]        settle_cnt_q, settle_cnt_d;
  logic              last_wr_q, last_wr_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              ref_ack_q, ref_ack_d;

  logic              wr_elig, rd_elig;
  logic              burst_done, wr_adv, rd_adv;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

`ifdef SDRAM_ARB_WDOG_EN
  localparam int unsigned       WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  assign wr_elig = wr_enable && (wr_level >= BURST_LVL);
  assign rd_elig = rd_enable && (rd_space >= BURST_LVL);

  // cmd_op_q is held through WAIT, so it still names the burst that completes.
  assign burst_done = (state_q == ST_WAIT) && cmd_done;
  assign wr_adv     = burst_done && (cmd_op_q == OP_WR);
  assign rd_adv     = burst_done && (cmd_op_q == OP_RD);

  sdram_burst_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_wr_addr (
    .clk        (clk),
    .rst        (rst),
    .advance    (wr_adv),
    .addr       (wr_addr),
    .frame_done (wr_frame_done)
  );

  sdram_burst_addr_gen #(
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_rd_addr (
    .clk        (clk),
    .rst        (rst),
    .advance    (rd_adv),
    .addr       (rd_addr),
    .frame_done (rd_frame_done)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    last_wr_d    = last_wr_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_op_d     = cmd_op_q;
    cmd_addr_d   = cmd_addr_q;
    ref_ack_d    = 1'b0;
`ifdef SDRAM_ARB_WDOG_EN
    wdog_cnt_d   = wdog_cnt_q;
    wdog_err_d   = wdog_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ref_req) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_REF;
          cmd_addr_d  = '0;
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_WR;
          cmd_addr_d  = wr_addr;
          last_wr_d   = 1'b1;
        end else if (rd_elig) begin
          state_d     = ST_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_op_d    = OP_RD;
          cmd_addr_d  = rd_addr;
          last_wr_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_WAIT;
          cmd_valid_d = 1'b0;
          ref_ack_d   = (cmd_op_q == OP_REF);
`ifdef SDRAM_ARB_WDOG_EN
          wdog_cnt_d  = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (cmd_done) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LAST;
`ifdef SDRAM_ARB_WDOG_EN
        end else if (wdog_cnt_q == WDOG_LAST) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = SETTLE_LAST;
          wdog_err_d   = 1'b1;
        end else begin
          wdog_cnt_d   = wdog_cnt_q + 1'b1;
`endif
        end
      end
      ST_SETTLE: begin
        // Lets the synchronised levels catch up before the next evaluation.
        if (settle_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      last_wr_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= OP_NONE;
      cmd_addr_q   <= '0;
      ref_ack_q    <= 1'b0;
`ifdef SDRAM_ARB_WDOG_EN
      wdog_cnt_q   <= '0;
      wdog_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      last_wr_q    <= last_wr_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_addr_q   <= cmd_addr_d;
      ref_ack_q    <= ref_ack_d;
`ifdef SDRAM_ARB_WDOG_EN
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_err_q   <= wdog_err_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_addr  = cmd_addr_q;
  assign ref_ack   = ref_ack_q;
`ifdef SDRAM_ARB_WDOG_EN
  assign wdog_err  = wdog_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_burst_arbiter                                               |
// | Directed vector bench for sdram_burst_arbiter (FRAME_WORDS=256).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdram_burst_arbiter;

  localparam int FAS = 9;
  localparam int BL  = 64;
  localparam int AW  = 22;
  localparam int FW  = 256;
  localparam int WD  = 16;

  logic          clk;
  logic          rst;
  logic          wr_enable, rd_enable;
  logic [FAS:0]  wr_level, rd_space;
  logic          ref_req, ref_ack;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ready, cmd_done;
  logic          wr_frame_done, rd_frame_done;
`ifdef SDRAM_ARB_WDOG_EN
  logic          wdog_err;
`endif

  int checks = 0;
  int errors = 0;

  sdram_burst_arbiter #(
    .FIFO_ADDR_SIZE (FAS),
    .BURST_LEN      (BL),
    .ADDR_W         (AW),
    .FRAME_WORDS    (FW),
    .WDOG_CYCLES    (WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_enable     (wr_enable),
    .rd_enable     (rd_enable),
    .wr_level      (wr_level),
    .rd_space      (rd_space),
    .ref_req       (ref_req),
    .ref_ack       (ref_ack),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_ready     (cmd_ready),
    .cmd_done      (cmd_done),
    .wr_frame_done (wr_frame_done),
    .rd_frame_done (rd_frame_done)
`ifdef SDRAM_ARB_WDOG_EN
    ,
    .wdog_err      (wdog_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr_en;
    logic          rd_en;
    logic [FAS:0]  wr_lvl;
    logic [FAS:0]  rd_sp;
    logic          ref_r;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic          wfd;
    logic          rfd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic we, input logic re, input logic [FAS:0] wl,
                            input logic [FAS:0] rs, input logic rr);
    wr_enable = we;
    rd_enable = re;
    wr_level  = wl;
    rd_space  = rs;
    ref_req   = rr;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!cmd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) check("valid_timeout", {63'd0, cmd_valid}, 64'd1);
  endtask

  // Handshake, ack checks, then cmd_done three cycles later and frame-done checks.
  task automatic do_burst(input string tag, input logic [1:0] op,
                          input logic wfd, input logic rfd);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, cmd_valid}, 64'd0);
    check({tag, "_ref_ack"}, {63'd0, ref_ack}, {63'd0, (op == 2'b11)});
    if (op == 2'b11) ref_req = 1'b0;
    @(negedge clk);
    check({tag, "_ref_ack_end"}, {63'd0, ref_ack}, 64'd0);
    repeat (3) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check({tag, "_frame_done"}, {62'd0, wr_frame_done, rd_frame_done}, {62'd0, wfd, rfd});
  endtask

  initial begin
    int n;
    int vcnt;
    logic [AW-1:0] exp_addr;

    vecs[0]  = '{1'b1, 1'b0, 10'd64,  10'd0,   1'b0, 2'b01, 22'd0,   1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 10'd100, 10'd0,   1'b0, 2'b01, 22'd64,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b10, 22'd0,   1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b01, 22'd128, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b10, 22'd64,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b1, 2'b11, 22'd0,   1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b01, 22'd192, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 10'd63,  10'd64,  1'b0, 2'b10, 22'd128, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 10'd64,  10'd512, 1'b0, 2'b01, 22'd0,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 10'd300, 10'd200, 1'b0, 2'b10, 22'd192, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b01, 22'd64,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 10'd64,  10'd512, 1'b0, 2'b10, 22'd0,   1'b0, 1'b0};

    rst       = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    set_inputs(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {38'd0, cmd_valid, cmd_op, cmd_addr, ref_ack, wr_frame_done, rd_frame_done}, 64'd0);
`ifdef SDRAM_ARB_WDOG_EN
    check("reset_wdog", {63'd0, wdog_err}, 64'd0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_inputs(vecs[i].wr_en, vecs[i].rd_en, vecs[i].wr_lvl, vecs[i].rd_sp, vecs[i].ref_r);
      wait_valid(n);
      if (i > 0) check($sformatf("latency[%0d]", i), 64'(n), 64'd4);
      check($sformatf("op[%0d]", i), {62'd0, cmd_op}, {62'd0, vecs[i].op});
      check($sformatf("addr[%0d]", i), {42'd0, cmd_addr}, {42'd0, vecs[i].addr});
      if (i == 3) begin
        // Stall: engine not ready; enable drop and a stray cmd_done must not disturb the offer.
        wr_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
          cmd_done = (k == 4);
          @(negedge clk);
          check($sformatf("stall[%0d]", k), {39'd0, cmd_valid, cmd_op, cmd_addr},
                {39'd0, 1'b1, vecs[i].op, vecs[i].addr});
        end
        cmd_done = 1'b0;
      end
      do_burst($sformatf("v%0d", i), vecs[i].op, vecs[i].wfd, vecs[i].rfd);
    end

    // Nothing eligible (both levels one short of a burst), plus a stray cmd_done in IDLE.
    set_inputs(1'b1, 1'b1, 10'd63, 10'd63, 1'b0);
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      cmd_done = (k == 10);
      @(negedge clk);
      if (cmd_valid) vcnt++;
    end
    cmd_done = 1'b0;
    check("idle_no_grant", 64'(vcnt), 64'd0);
    wr_level = 10'd64;
    wait_valid(n);
    check("after_idle_op", {62'd0, cmd_op}, 64'd1);
    check("after_idle_addr", {42'd0, cmd_addr}, 64'd128);
    do_burst("after_idle", 2'b01, 1'b0, 1'b0);
    exp_addr = 22'd192;

`ifdef SDRAM_ARB_WDOG_EN
    set_inputs(1'b1, 1'b0, 10'd64, 10'd0, 1'b0);
    wait_valid(n);
    check("wdog_op", {62'd0, cmd_op}, 64'd1);
    check("wdog_addr", {42'd0, cmd_addr}, 64'd192);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    n = 1;
    while (!wdog_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wdog_latency", 64'(n), 64'd17);
    wait_valid(n);
    check("wdog_relaunch_lat", 64'(n), 64'd4);
    check("wdog_reuse_addr", {42'd0, cmd_addr}, 64'd192);
    do_burst("wdog_retry", 2'b01, 1'b1, 1'b0);
    check("wdog_sticky", {63'd0, wdog_err}, 64'd1);
    exp_addr = 22'd0;
`endif

    // Reset while a command is being offered.
    set_inputs(1'b1, 1'b0, 10'd64, 10'd0, 1'b0);
    wait_valid(n);
    check("pre_reset_addr", {42'd0, cmd_addr}, {42'd0, exp_addr});
    rst = 1'b0;
    set_inputs(1'b1, 1'b1, 10'd64, 10'd512, 1'b0);
    repeat (2) @(negedge clk);
    check("midreset_outputs", {38'd0, cmd_valid, cmd_op, cmd_addr, ref_ack, wr_frame_done, rd_frame_done}, 64'd0);
`ifdef SDRAM_ARB_WDOG_EN
    check("midreset_wdog", {63'd0, wdog_err}, 64'd0);
`endif
    rst = 1'b1;
    wait_valid(n);
    check("post_reset_op", {62'd0, cmd_op}, 64'd1);
    check("post_reset_addr", {42'd0, cmd_addr}, 64'd0);
    do_burst("post_reset", 2'b01, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
